// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, the captured request
// and the address fault rule used when DMEM_ERR_CHECK_EN is defined.
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  // Misaligned, or beyond the DEPTH-word window.
  function automatic logic addr_fault(input logic [31:0] addr, input int aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port DEPTH x 32 storage, one byte-wide bank per lane.
// Read data is registered and appears the cycle after i_en.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                 i_clk,
  input  logic                 i_en,
  input  logic                 i_we,
  input  logic [BE_W-1:0]      i_be,
  input  logic [AW-1:0]        i_addr,
  input  logic [BE_W-1:0][7:0] i_wdata,
  output logic [BE_W-1:0][7:0] o_rdata
);

  for (genvar l = 0; l < BE_W; l++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge i_clk) begin
      if (i_en) begin
        if (i_we && i_be[l]) r_mem[i_addr] <= i_wdata[l];
        r_q <= r_mem[i_addr];
      end
    end

    assign o_rdata[l] = r_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time, WAIT_CYCLES of added latency.
// Optional address fault checking under the DMEM_ERR_CHECK_EN macro.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [31:0]       i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [BE_W-1:0]   i_req_be,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t              r_state;
  logic [3:0]          r_cnt;
  req_t                r_req;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic                w_fault;
  logic                w_arr_en;
  logic                w_arr_we;
  logic [BE_W-1:0][7:0] w_q;

`ifdef DMEM_ERR_CHECK_EN
  assign w_fault = addr_fault(r_req.addr, AW);
`else
  assign w_fault = 1'b0;
  logic w_unused_addr;
  assign w_unused_addr = ^{r_req.addr[31:AW+2], r_req.addr[1:0]};
`endif

  assign o_req_ready = (r_state == IDLE) && i_reset;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  assign w_arr_en = (r_state == ACCESS);
  assign w_arr_we = r_req.we && !w_fault;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .i_clk   (i_clk),
    .i_en    (w_arr_en),
    .i_we    (w_arr_we),
    .i_be    (r_req.be),
    .i_addr  (r_req.addr[AW+1:2]),
    .i_wdata (r_req.wdata),
    .o_rdata (w_q)
  );

  // The array read port is registered, so the first RESP cycle latches its
  // output into the response registers before rsp_valid is raised.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_req       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_req   <= '{we: i_req_we, addr: i_req_addr, wdata: i_req_wdata, be: i_req_be};
            r_cnt   <= 4'd0;
            r_state <= (LP_WAIT != 4'd0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt + 4'd1 == LP_WAIT) r_state <= ACCESS;
        end
        ACCESS: r_state <= RESP;
        RESP: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (r_req.we || w_fault) ? '0 : w_q;
            r_rsp_err   <= w_fault;
          end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances, a vector
// table, stall/reset sequences and a randomized run against a word-array model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        rv2, rr2, pv2, pr2, er2;
  logic [31:0] rd2;
  logic        rv0, rr0, pv0, pr0, er0;
  logic [31:0] rd0;

  dmem_responder #(.DEPTH(64), .AW(6), .WAIT_CYCLES(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(rv2), .o_req_ready(rr2),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(pv2), .i_rsp_ready(pr2), .o_rsp_rdata(rd2), .o_rsp_err(er2)
  );

  dmem_responder #(.DEPTH(64), .AW(6), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(rv0), .o_req_ready(rr0),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(pv0), .i_rsp_ready(pr0), .o_rsp_rdata(rd0), .o_rsp_err(er0)
  );

`ifdef DMEM_ERR_CHECK_EN
  localparam logic [31:0] E100_RD = 32'h0;
  localparam logic [31:0] E12_RD  = 32'h0;
  localparam logic        E_ERR   = 1'b1;
`else
  localparam logic [31:0] E100_RD = 32'h5A5A0000;
  localparam logic [31:0] E12_RD  = 32'hDEADBEAA;
  localparam logic        E_ERR   = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One full transaction with rsp_ready held high; lat = edges from accept to rsp_valid.
  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] rd, output logic er, output int lat);
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    if (sel != 0) rv2 = 1'b1; else rv0 = 1'b1;
    for (int k = 0; k < 20 && !((sel != 0) ? rr2 : rr0); k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rv2 = 1'b0; rv0 = 1'b0;
    lat = 0;
    while (!((sel != 0) ? pv2 : pv0) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = (sel != 0) ? rd2 : rd0;
    er = (sel != 0) ? er2 : er0;
    @(posedge clk); #1;
  endtask

  logic [31:0] mdl [64];
  vec_t        vt [11];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we;

    vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,         1'b0};
    vt[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF,  1'b0};
    vt[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,         1'b0};
    vt[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA,  1'b0};
    vt[4]  = '{1'b1, 32'h10,  32'h12345678, 4'h0, 32'h0,         1'b0};
    vt[5]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA,  1'b0};
    vt[6]  = '{1'b1, 32'h14,  32'h01020304, 4'hF, 32'h0,         1'b0};
    vt[7]  = '{1'b1, 32'h14,  32'hAABBCCDD, 4'hA, 32'h0,         1'b0};
    vt[8]  = '{1'b0, 32'h14,  32'h0,        4'h0, 32'hAA02CC04,  1'b0};
    vt[9]  = '{1'b1, 32'h00,  32'h5A5A0000, 4'hF, 32'h0,         1'b0};
    vt[10] = '{1'b0, 32'h100, 32'h0,        4'h0, E100_RD,       E_ERR};

    rst_n = 1'b0; rv2 = 1'b0; rv0 = 1'b0; pr2 = 1'b1; pr0 = 1'b1;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready2", rr2, 0);
    chk("rst_rsp_valid2", pv2, 0);
    chk("rst_rdata2", rd2, 0);
    chk("rst_err2", er2, 0);
    chk("rst_req_ready0", rr0, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready2", rr2, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      txn(1, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), er, vt[i].exp_err);
      chk($sformatf("vec%0d_lat", i), lat, 4);
      chk($sformatf("vec%0d_idle", i), rr2, 1);
    end
    txn(1, 1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
    chk("misalign_rdata", rd, E12_RD);
    chk("misalign_err", er, E_ERR);

    // Zero-wait instance: response held under back-pressure.
    txn(0, 1'b1, 32'h08, 32'h13572468, 4'hF, rd, er, lat);
    chk("w0_store_lat", lat, 2);
    pr0 = 1'b0;
    req_we = 1'b0; req_addr = 32'h08; rv0 = 1'b1;
    @(posedge clk); #1;
    rv0 = 1'b0;
    lat = 0;
    while (!pv0 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("w0_load_lat", lat, 2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", c), pv0, 1);
      chk($sformatf("stall%0d_rdata", c), rd0, 32'h13572468);
      chk($sformatf("stall%0d_ready", c), rr0, 0);
    end
    pr0 = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", pv0, 0);
    chk("stall_release_idle", rr0, 1);

    // Asynchronous reset while a response is pending (between clock edges).
    pr0 = 1'b0;
    rv0 = 1'b1;
    @(posedge clk); #1;
    rv0 = 1'b0;
    lat = 0;
    while (!pv0 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("async_pre_valid", pv0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", pv0, 0);
    chk("async_rdata", rd0, 0);
    chk("async_err", er0, 0);
    chk("async_ready0", rr0, 0);
    chk("async_ready2", rr2, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; pr0 = 1'b1;
    #1;
    chk("async_after_ready0", rr0, 1);
    @(posedge clk); #1;

    // Reset during WAIT of a store must not write.
    txn(1, 1'b1, 32'h20, 32'h11111111, 4'hF, rd, er, lat);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_be = 4'hF; rv2 = 1'b1;
    @(posedge clk); #1;
    rv2 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("wait_rst_ready", rr2, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("wait_rst_word", rd, 32'h11111111);

    // Randomized run against the word-array model.
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      txn(1, 1'b1, 32'(w * 4), wd, 4'hF, rd, er, lat);
      mdl[w] = wd;
    end
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63)) * 4;
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      txn(1, we, a, wd, be, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", n), rd, we ? 32'h0 : mdl[a[7:2]]);
      chk($sformatf("rnd%0d_lat_err", n), {lat[30:0], er}, {31'd4, 1'b0});
      if (we) mdl[a[7:2]] = merge(mdl[a[7:2]], wd, be);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the core's load/store port. The processor core is the initiator; this block accepts one request at a time, waits a programmable number of cycles, and returns a response.
- Word-organised storage of DEPTH x DATA_W, with byte-enable writes.
- Replaces the core's zero-latency data memory so the bench can exercise stall paths.

Parameters:
- DATA_W, 32, data width in bits; fixed at 32 (byte enables assume 4 lanes).
- DEPTH, 64, number of words; power of two.
- AW, 6, word-address width, equal to log2(DEPTH).
- WAIT_CYCLES, 2, added latency cycles between accept and response; legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; asserted at 0.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte-lane write enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  request faulted (see Optional Feature).

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while reset is held. Memory contents are not cleared by reset.
- req_ready is a combinational decode of state==IDLE, gated by reset deasserted.
- States and transitions:
  - IDLE: on req_valid&&req_ready, capture we/addr/wdata/be. Go to WAIT if WAIT_CYCLES>0, else to ACCESS.
  - WAIT: counter counts 1..WAIT_CYCLES. When it reaches WAIT_CYCLES, go to ACCESS.
  - ACCESS (one cycle): perform the array read or write on the captured request. Register rsp_rdata and rsp_err. Go to RESP.
  - RESP: hold rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready=1. On the handshake, go to IDLE.
- Latency: request accepted at edge N, rsp_valid first high after edge N+2+WAIT_CYCLES. With rsp_ready tied 1, the next request can be accepted 1 cycle after the response handshake.
- Word index = req_addr[AW+1:2].
- Store: write only the lanes whose req_be bit is set. req_be=0 leaves memory unchanged but still produces a response. Store response has rsp_rdata=0.
- Load: return the full word. A load issued after a store to the same address returns the stored data, since the write completes in ACCESS before any later accept.
- req_valid during WAIT/ACCESS/RESP is ignored (req_ready=0). Request inputs are not sampled outside IDLE.
- rsp_ready held low: stay in RESP indefinitely with outputs frozen.
- Reset mid-transaction: abort immediately. A store that has not reached ACCESS is not written. A store in its ACCESS cycle may leave the target word indeterminate.

Optional Feature:
- Macro DMEM_ERR_CHECK_EN.
- Defined:
  - A request faults if req_addr[1:0]!=0 or req_addr[31:AW+2]!=0.
  - A faulted request follows normal timing but performs no write; rsp_rdata=0 and rsp_err=1.
- Undefined:
  - Low 2 bits and upper bits are ignored, so addresses wrap modulo DEPTH words.
  - rsp_err is tied to 0.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, ACCESS, RESP};
  - DATA_W and BE_W=DATA_W/8 constants;
  - packed struct for a captured request {we, addr, wdata, be}.
- Sub-module dmem_array: synchronous single-port DEPTH x 32 storage with 4 byte write enables. The controller FSM stays in dmem_responder.

Test Plan:
- Store 0xDEADBEEF to 0x10 with be=4'hF, then load 0x10 (WAIT_CYCLES=2) -> rdata=0xDEADBEEF, rsp_valid 4 cycles after each accept.
- Store 0x000000AA to 0x10 with be=4'b0001 over the previous value -> load returns 0xDEADBEAA. A store with be=0 leaves 0xDEADBEAA.
- With WAIT_CYCLES=0, hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stay stable and req_ready stays 0. Raising rsp_ready gives IDLE next cycle.
- Assert reset (0) during WAIT of a store to 0x20 holding 0x11111111 -> the word at 0x20 still reads 0x11111111, and all outputs return to reset values asynchronously.
- With DMEM_ERR_CHECK_EN, load at 0x12 and at 0x100 -> rsp_err=1, rdata=0. Without the macro, 0x100 aliases word 0 and returns its data with rsp_err=0.
